// File: rtl/motor_speed_ctrl_if.sv
// motor_speed_ctrl_if: Nios PIO control/status bundle for the motor speed controller
interface motor_speed_ctrl_if #(
  parameter int VEL_W = 16,
  parameter int POS_W = 32,
  parameter int GAIN_W = 8,
  parameter int PWM_BITS = 10
);
  logic enable;
  logic clr_err;
  logic signed [VEL_W-1:0] setpoint;
  logic [GAIN_W-1:0] kp;
  logic [GAIN_W-1:0] ki;
  logic signed [POS_W-1:0] position;
  logic signed [VEL_W-1:0] velocity;
  logic signed [PWM_BITS:0] duty;
  logic sample_stb;
  logic enc_err;
  modport master (
    output enable, clr_err, setpoint, kp, ki,
    input position, velocity, duty, sample_stb, enc_err
  );
  modport slave (
    input enable, clr_err, setpoint, kp, ki,
    output position, velocity, duty, sample_stb, enc_err
  );
endinterface

// File: rtl/motor_speed_ctrl.sv
// motor_speed_ctrl: quadrature-decoded PI speed loop driving a two-line H-bridge PWM
// Define MOTOR_SPEED_CTRL_SYNC_EN to pass enc_ab through a 2-flop synchronizer.
module motor_speed_ctrl #(
  parameter int PWM_BITS = 10,
  parameter int SAMPLE_DIV = 50000,
  parameter int VEL_W = 16,
  parameter int POS_W = 32,
  parameter int GAIN_W = 8,
  parameter int SHIFT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic [1:0] enc_ab,
  output logic [1:0] pwm_out,
  motor_speed_ctrl_if.slave bus
);
  localparam int PWM_MAX = 2**PWM_BITS - 1;
  localparam int AW = VEL_W + GAIN_W + PWM_BITS + SHIFT + 2;
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam logic signed [AW-1:0] UMAX = AW'(PWM_MAX);
  localparam logic signed [AW-1:0] ILIM = UMAX <<< SHIFT;
  localparam logic signed [PWM_BITS:0] DMAX = (PWM_BITS+1)'(PWM_MAX);
  localparam logic signed [POS_W-1:0] VMAX = POS_W'({(VEL_W-1){1'b1}});
  localparam logic signed [POS_W-1:0] VMIN = -VMAX - POS_W'(1);
  typedef enum logic [2:0] {IDLE, WAIT, ERR, MUL, ACC, OUT} state_t;
  state_t state, state_n;
  logic [1:0] ab_in, ab_q;
  logic signed [POS_W-1:0] pos, snap, diff;
  logic signed [VEL_W-1:0] vel;
  logic [TW-1:0] tcnt;
  logic tick, enc_err, stb, en_q;
  logic signed [VEL_W:0] err;
  logic signed [AW-1:0] err_x, kp_x, ki_x, p, ii, integ, acc_s, acc_c, out_s, out_sh;
  logic signed [PWM_BITS:0] u, duty_n, duty, duty_neg;
  logic [PWM_BITS-1:0] pcnt, mag;

`ifdef MOTOR_SPEED_CTRL_SYNC_EN
  logic [1:0] s1, s2;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= enc_ab;
      s2 <= s1;
    end
  end
  assign ab_in = s2;
`else
  assign ab_in = enc_ab;
`endif

  always_comb begin
    diff = pos - snap;
    tick = state != IDLE && bus.enable && tcnt == TW'(SAMPLE_DIV - 1);
    err_x = AW'(err);
    kp_x = AW'({1'b0, bus.kp});
    ki_x = AW'({1'b0, bus.ki});
    acc_s = integ + ii;
    acc_c = acc_s > ILIM ? ILIM : acc_s < -ILIM ? -ILIM : acc_s;
    out_s = p + integ;
    out_sh = out_s >>> SHIFT;
    // symmetric clamp: -2^PWM_BITS is never produced
    u = out_sh > UMAX ? DMAX : out_sh < -UMAX ? -DMAX : out_sh[PWM_BITS:0];
    duty_neg = -duty;
    mag = duty[PWM_BITS] ? duty_neg[PWM_BITS-1:0] : duty[PWM_BITS-1:0];
    pwm_out = !en_q || pcnt >= mag ? 2'b00 : duty[PWM_BITS] ? 2'b10 : 2'b01;
    state_n = !bus.enable ? IDLE :
              state == IDLE ? WAIT :
              state == WAIT ? (tick ? ERR : WAIT) :
              state == ERR ? MUL :
              state == MUL ? ACC :
              state == ACC ? OUT : WAIT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ab_q <= '0;
      pos <= '0;
      enc_err <= 1'b0;
      snap <= '0;
      vel <= '0;
      tcnt <= '0;
      err <= '0;
      p <= '0;
      ii <= '0;
      integ <= '0;
      duty_n <= '0;
      duty <= '0;
      stb <= 1'b0;
      en_q <= 1'b0;
      pcnt <= '0;
    end else begin
      ab_q <= ab_in;
      if (ab_in != ab_q && !(&(ab_in ^ ab_q)))
        pos <= (ab_q[1] ^ ab_in[0]) ? pos + POS_W'(1) : pos - POS_W'(1);
      enc_err <= (&(ab_in ^ ab_q)) | (enc_err & ~bus.clr_err);
      // snapshot tracks position while idle so the first velocity covers only enabled time
      if (state == IDLE || !bus.enable) begin
        tcnt <= '0;
        snap <= pos;
      end else if (tick) begin
        tcnt <= '0;
        snap <= pos;
        vel <= diff > VMAX ? {1'b0, {(VEL_W-1){1'b1}}} :
               diff < VMIN ? {1'b1, {(VEL_W-1){1'b0}}} : diff[VEL_W-1:0];
      end else tcnt <= tcnt + TW'(1);
      if (state == ERR) err <= {bus.setpoint[VEL_W-1], bus.setpoint} - {vel[VEL_W-1], vel};
      if (state == MUL) begin
        p <= err_x * kp_x;
        ii <= err_x * ki_x;
      end
      integ <= (!bus.enable || state == IDLE) ? '0 : state == ACC ? acc_c : integ;
      duty_n <= (!bus.enable || state == IDLE) ? '0 : state == OUT ? u : duty_n;
      stb <= bus.enable && state == OUT;
      en_q <= bus.enable;
      pcnt <= pcnt + PWM_BITS'(1);
      if (&pcnt) duty <= duty_n;
    end
  end

  assign bus.position = pos;
  assign bus.velocity = vel;
  assign bus.duty = duty;
  assign bus.sample_stb = stb;
  assign bus.enc_err = enc_err;
endmodule
